fetch_unit: RTL and testbench

//   Instruction fetch stage of the RISC16 core. Owns the program counter (PC),

---
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit.sv | 92 +++++++++
 tb/tb_fetch_unit.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Bus between the fetch stage and its neighbours: instruction memory, hazard
// unit, branch resolution and the IF/ID consumer.
interface fetch_unit_if;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] pc_out;
  logic [15:0] instr_in;
  logic        ifid_valid;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc;
  logic [15:0] ifid_pc_plus2;
  logic [15:0] fetch_count;

  // The fetch stage itself.
  modport slave (
    input  stall, redirect_valid, redirect_pc, instr_in,
    output pc_out, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus2, fetch_count
  );

  // The surrounding pipeline and memory.
  modport master (
    output stall, redirect_valid, redirect_pc, instr_in,
    input  pc_out, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus2, fetch_count
  );
endinterface

// File: rtl/fetch_unit.sv
// RISC16 instruction fetch stage: owns the PC, captures the instruction from a
// combinational memory into IF/ID, handles stall and branch redirect/flush.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned PC_STEP  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.slave  bus
);

  // Bit 0 is forced low so a misconfigured reset vector still fetches aligned.
  localparam logic [15:0] RESET_PC_ALIGNED = {RESET_PC[15:1], 1'b0};
  localparam logic [15:0] STEP             = 16'(PC_STEP);

  typedef enum logic [1:0] {
    ACT_ADVANCE  = 2'd0,
    ACT_STALL    = 2'd1,
    ACT_REDIRECT = 2'd2
  } action_t;

  logic [15:0] r_pc;
  logic        r_ifid_valid;
  logic [15:0] r_ifid_instr;
  logic [15:0] r_ifid_pc;
  logic [15:0] r_ifid_pc_plus2;
  logic [15:0] r_fetch_count;

  action_t     w_action;
  logic [15:0] w_pc_inc;
  logic [15:0] w_target;
  logic [15:0] w_count_next;

  assign w_pc_inc = r_pc + STEP;
  assign w_target = {bus.redirect_pc[15:1], 1'b0};

  always_comb begin
    w_action = ACT_ADVANCE;
    if (bus.redirect_valid) begin
      w_action = ACT_REDIRECT;
    end else if (bus.stall) begin
      w_action = ACT_STALL;
    end
  end

  // Debug counter sticks at all-ones rather than wrapping.
  always_comb begin
    w_count_next = r_fetch_count;
    if (r_fetch_count != 16'hFFFF) begin
      w_count_next = r_fetch_count + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc            <= RESET_PC_ALIGNED;
      r_ifid_valid    <= 1'b0;
      r_ifid_instr    <= 16'h0000;
      r_ifid_pc       <= 16'h0000;
      r_ifid_pc_plus2 <= 16'h0000;
      r_fetch_count   <= 16'h0000;
    end else begin
      case (w_action)
        ACT_REDIRECT: begin
          // Flush the wrong-path capture; ifid_pc fields are left stale on purpose.
          r_pc         <= w_target;
          r_ifid_valid <= 1'b0;
          r_ifid_instr <= 16'h0000;
        end
        ACT_STALL: begin
          r_pc <= r_pc;
        end
        default: begin
          r_pc            <= w_pc_inc;
          r_ifid_valid    <= 1'b1;
          r_ifid_instr    <= bus.instr_in;
          r_ifid_pc       <= r_pc;
          r_ifid_pc_plus2 <= w_pc_inc;
          r_fetch_count   <= w_count_next;
        end
      endcase
    end
  end

  assign bus.pc_out        = r_pc;
  assign bus.ifid_valid    = r_ifid_valid;
  assign bus.ifid_instr    = r_ifid_instr;
  assign bus.ifid_pc       = r_ifid_pc;
  assign bus.ifid_pc_plus2 = r_ifid_pc_plus2;
  assign bus.fetch_count   = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: free run, stall, redirect, wrap, async reset
// and counter saturation against a small combinational memory.
module tb_fetch_unit;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(16'h0000), .PC_STEP(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Words A..D at 0,2,4,6; elsewhere a pattern derived from the address.
  always_comb begin
    case (bus.pc_out)
      16'h0000: bus.instr_in = 16'h1111;
      16'h0002: bus.instr_in = 16'h2222;
      16'h0004: bus.instr_in = 16'h3333;
      16'h0006: bus.instr_in = 16'h4444;
      default:  bus.instr_in = bus.pc_out ^ 16'hBEEF;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 16'h0000;
    #2;
    checks++;
    if (bus.pc_out !== 16'h0000 || bus.ifid_valid !== 1'b0 || bus.ifid_instr !== 16'h0000 ||
        bus.ifid_pc !== 16'h0000 || bus.ifid_pc_plus2 !== 16'h0000 || bus.fetch_count !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: pc=%h v=%b instr=%h ipc=%h p2=%h cnt=%h, want all zero",
               bus.pc_out, bus.ifid_valid, bus.ifid_instr, bus.ifid_pc, bus.ifid_pc_plus2, bus.fetch_count);
    end
    $display("reset: pc_out=%h fetch_count=%h", bus.pc_out, bus.fetch_count);
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_free_run();
    logic [15:0] exp_instr [4];
    exp_instr[0] = 16'h1111; exp_instr[1] = 16'h2222;
    exp_instr[2] = 16'h3333; exp_instr[3] = 16'h4444;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bus.ifid_instr !== exp_instr[i] || bus.ifid_pc !== 16'(2*i) ||
          bus.ifid_pc_plus2 !== 16'(2*i+2) || bus.ifid_valid !== 1'b1 ||
          bus.fetch_count !== 16'(i+1)) begin
        errors++;
        $display("FAIL free_run_%0d: instr=%h pc=%h p2=%h v=%b cnt=%h, want %h %h %h 1 %h",
                 i, bus.ifid_instr, bus.ifid_pc, bus.ifid_pc_plus2, bus.ifid_valid, bus.fetch_count,
                 exp_instr[i], 16'(2*i), 16'(2*i+2), 16'(i+1));
      end
      $display("free_run %0d: ifid_pc=%h ifid_instr=%h", i, bus.ifid_pc, bus.ifid_instr);
    end
    checks++;
    if (bus.pc_out !== 16'h0008) begin
      errors++;
      $display("FAIL free_run_pc_out: got %h want 0008", bus.pc_out);
    end
  endtask

  task automatic test_stall();
    #3 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    step();
    step();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.pc_out !== 16'h0004 || bus.ifid_instr !== 16'h2222 || bus.fetch_count !== 16'h0002 ||
          bus.ifid_pc !== 16'h0002 || bus.ifid_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold_%0d: pc=%h instr=%h cnt=%h ipc=%h v=%b, want 0004 2222 0002 0002 1",
                 i, bus.pc_out, bus.ifid_instr, bus.fetch_count, bus.ifid_pc, bus.ifid_valid);
      end
      $display("stall %0d: pc_out=%h ifid_instr=%h", i, bus.pc_out, bus.ifid_instr);
    end
    bus.stall = 1'b0;
    step();
    checks++;
    if (bus.ifid_instr !== 16'h3333 || bus.ifid_pc !== 16'h0004 || bus.fetch_count !== 16'h0003 ||
        bus.pc_out !== 16'h0006) begin
      errors++;
      $display("FAIL stall_release: instr=%h ipc=%h cnt=%h pc=%h, want 3333 0004 0003 0006",
               bus.ifid_instr, bus.ifid_pc, bus.fetch_count, bus.pc_out);
    end
    $display("stall release: ifid_instr=%h", bus.ifid_instr);
  endtask

  task automatic test_redirect();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 16'h0011;
    step();
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.pc_out !== 16'h0010 || bus.ifid_valid !== 1'b0 || bus.ifid_instr !== 16'h0000 ||
        bus.fetch_count !== 16'h0003 || bus.ifid_pc !== 16'h0004) begin
      errors++;
      $display("FAIL redirect_flush: pc=%h v=%b instr=%h cnt=%h ipc=%h, want 0010 0 0000 0003 0004",
               bus.pc_out, bus.ifid_valid, bus.ifid_instr, bus.fetch_count, bus.ifid_pc);
    end
    step();
    checks++;
    if (bus.ifid_pc !== 16'h0010 || bus.ifid_valid !== 1'b1 || bus.ifid_instr !== 16'hBEFF ||
        bus.ifid_pc_plus2 !== 16'h0012 || bus.pc_out !== 16'h0012 || bus.fetch_count !== 16'h0004) begin
      errors++;
      $display("FAIL redirect_target: ipc=%h v=%b instr=%h p2=%h pc=%h cnt=%h, want 0010 1 BEFF 0012 0012 0004",
               bus.ifid_pc, bus.ifid_valid, bus.ifid_instr, bus.ifid_pc_plus2, bus.pc_out, bus.fetch_count);
    end
    $display("redirect: ifid_pc=%h ifid_instr=%h", bus.ifid_pc, bus.ifid_instr);
  endtask

  task automatic test_redirect_stall();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 16'h0030;
    bus.stall = 1'b1;
    step();
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.pc_out !== 16'h0030 || bus.ifid_valid !== 1'b0 || bus.fetch_count !== 16'h0004) begin
      errors++;
      $display("FAIL redirect_over_stall: pc=%h v=%b cnt=%h, want 0030 0 0004",
               bus.pc_out, bus.ifid_valid, bus.fetch_count);
    end
    step();
    checks++;
    if (bus.pc_out !== 16'h0030 || bus.ifid_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_after_redirect: pc=%h v=%b, want 0030 0", bus.pc_out, bus.ifid_valid);
    end
    bus.stall = 1'b0;
    $display("redirect+stall: pc_out=%h", bus.pc_out);
  endtask

  task automatic test_wrap();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 16'hFFFE;
    step();
    bus.redirect_valid = 1'b0;
    step();
    checks++;
    if (bus.ifid_pc !== 16'hFFFE || bus.ifid_pc_plus2 !== 16'h0000 || bus.ifid_instr !== 16'h4111 ||
        bus.pc_out !== 16'h0000 || bus.fetch_count !== 16'h0005) begin
      errors++;
      $display("FAIL wrap_first: ipc=%h p2=%h instr=%h pc=%h cnt=%h, want FFFE 0000 4111 0000 0005",
               bus.ifid_pc, bus.ifid_pc_plus2, bus.ifid_instr, bus.pc_out, bus.fetch_count);
    end
    step();
    checks++;
    if (bus.ifid_pc !== 16'h0000 || bus.ifid_pc_plus2 !== 16'h0002 || bus.ifid_instr !== 16'h1111 ||
        bus.pc_out !== 16'h0002 || bus.fetch_count !== 16'h0006) begin
      errors++;
      $display("FAIL wrap_second: ipc=%h p2=%h instr=%h pc=%h cnt=%h, want 0000 0002 1111 0002 0006",
               bus.ifid_pc, bus.ifid_pc_plus2, bus.ifid_instr, bus.pc_out, bus.fetch_count);
    end
    $display("wrap: ifid_pc=%h ifid_pc_plus2=%h", bus.ifid_pc, bus.ifid_pc_plus2);
  endtask

  task automatic test_async_reset();
    bus.stall = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.pc_out !== 16'h0000 || bus.ifid_valid !== 1'b0 || bus.ifid_instr !== 16'h0000 ||
        bus.ifid_pc !== 16'h0000 || bus.ifid_pc_plus2 !== 16'h0000 || bus.fetch_count !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset: pc=%h v=%b instr=%h ipc=%h p2=%h cnt=%h, want all zero",
               bus.pc_out, bus.ifid_valid, bus.ifid_instr, bus.ifid_pc, bus.ifid_pc_plus2, bus.fetch_count);
    end
    bus.stall = 1'b0;
    step();
    checks++;
    if (bus.pc_out !== 16'h0000 || bus.fetch_count !== 16'h0000 || bus.ifid_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: pc=%h cnt=%h v=%b, want 0000 0000 0", bus.pc_out, bus.fetch_count, bus.ifid_valid);
    end
    rst_n = 1'b1;
    $display("async reset: pc_out=%h", bus.pc_out);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 65534; i++) begin
      @(posedge clk);
    end
    #1;
    checks++;
    if (bus.fetch_count !== 16'hFFFE || bus.pc_out !== 16'hFFFC) begin
      errors++;
      $display("FAIL sat_preload: cnt=%h pc=%h, want FFFE FFFC", bus.fetch_count, bus.pc_out);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.fetch_count !== 16'hFFFF) begin
        errors++;
        $display("FAIL sat_%0d: cnt=%h want FFFF", i, bus.fetch_count);
      end
      $display("saturate %0d: fetch_count=%h", i, bus.fetch_count);
    end
    checks++;
    if (bus.pc_out !== 16'h0002 || bus.ifid_pc !== 16'h0000) begin
      errors++;
      $display("FAIL sat_pc: pc=%h ipc=%h, want 0002 0000", bus.pc_out, bus.ifid_pc);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_async_reset();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
